// File: rtl/ddram_port_sched.sv
// Per-requestor DDR3 port scheduler: posts core writes into a small FIFO and
// lets hazard-free burst reads overtake them, one downstream transaction at a time.
module ddram_port_sched #(
  parameter int DEPTH    = 8,
  parameter int WR_HIWAT = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic [28:0] cpu_wr_addr,
  input  logic [63:0] cpu_wr_data,
  input  logic [7:0]  cpu_wr_be,
  input  logic        cpu_wr_req,
  output logic        cpu_wr_ready,
  input  logic [28:0] cpu_rd_addr,
  input  logic [7:0]  cpu_rd_burstcnt,
  input  logic        cpu_rd_req,
  output logic        cpu_rd_ack,
  output logic [63:0] cpu_rd_data,
  output logic        cpu_rd_data_valid,
  output logic [28:0] dc_rd_addr,
  output logic [7:0]  dc_rd_burstcnt,
  output logic        dc_rd_req,
  input  logic        dc_rd_ack,
  input  logic [63:0] dc_rd_data,
  input  logic        dc_rd_data_valid,
  output logic [28:0] dc_wr_addr,
  output logic [63:0] dc_wr_data,
  output logic [7:0]  dc_wr_be,
  output logic [7:0]  dc_wr_burstcnt,
  output logic        dc_wr_req,
  input  logic        dc_wr_ack,
  input  logic        dc_wr_busy,
  output logic [5:0]  wr_pending,
  output logic        idle
);

  localparam int           PTR_W   = $clog2(DEPTH);
  localparam logic [5:0]   DEPTH_C = 6'(DEPTH);
  localparam logic [5:0]   HIWAT_C = 6'(WR_HIWAT);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD_REQ, S_RD_DATA} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [5:0]         count_q, count_d;
  logic [28:0]        addr_q, addr_d;
  logic [63:0]        data_q, data_d;
  logic [7:0]         be_q, be_d;
  logic [7:0]         burst_q, burst_d;
  logic [7:0]         remain_q, remain_d;
  logic               rd_squash_q, rd_squash_d;
  logic               wr_squash_q, wr_squash_d;
  logic               push, pop, hazard, rd_busy;
  logic [PTR_W-1:0]   slot_off;
  logic [28:0]        diff;
  logic               unused_busy;

  logic [28:0] addr_mem [DEPTH];
  logic [63:0] data_mem [DEPTH];
  logic [7:0]  be_mem   [DEPTH];

  assign unused_busy  = dc_wr_busy;
  assign cpu_wr_ready = (count_q < DEPTH_C) && !flush;
  assign push         = cpu_wr_req && cpu_wr_ready;
  assign rd_busy      = (state_q == S_RD_REQ) || (state_q == S_RD_DATA);

  // NOTE: queue storage has no reset; head/tail/count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_q] <= cpu_wr_addr;
      data_mem[tail_q] <= cpu_wr_data;
      be_mem[tail_q]   <= cpu_wr_be;
    end
  end

  // Read-after-write hazard: any valid entry inside [rd_addr, rd_addr+burstcnt) mod 2^29.
  always_comb begin
    hazard   = 1'b0;
    slot_off = '0;
    diff     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = PTR_W'(i) - head_q;
      diff     = addr_mem[i] - cpu_rd_addr;
      if ((6'(slot_off) < count_q) && (diff < {21'd0, cpu_rd_burstcnt}))
        hazard = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 6'd1;
    else if (pop && !push) count_d = count_q - 6'd1;
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    be_d        = be_q;
    burst_d     = burst_q;
    remain_d    = remain_q;
    rd_squash_d = rd_squash_q;
    wr_squash_d = wr_squash_q;
    pop         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        wr_squash_d = 1'b0;
        if (!flush && (count_q >= HIWAT_C)) begin
          state_d  = S_WR;
          addr_d   = addr_mem[head_q];
          data_d   = data_mem[head_q];
          be_d     = be_mem[head_q];
          burst_d  = 8'd1;
          remain_d = 8'd1;
        end else if (cpu_rd_req && (flush || !hazard)) begin
          state_d  = S_RD_REQ;
          addr_d   = cpu_rd_addr;
          burst_d  = cpu_rd_burstcnt;
          remain_d = cpu_rd_burstcnt;
        end else if (!flush && (count_q != 6'd0)) begin
          state_d  = S_WR;
          addr_d   = addr_mem[head_q];
          data_d   = data_mem[head_q];
          be_d     = be_mem[head_q];
          burst_d  = 8'd1;
          remain_d = 8'd1;
        end
      end
      S_WR: begin
        if (flush) wr_squash_d = 1'b1;
        if (dc_wr_ack) begin
          pop         = !wr_squash_q && !flush;
          wr_squash_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_RD_REQ: begin
        if (dc_rd_ack) begin
          if (remain_q == 8'd0) begin
            state_d = S_IDLE;
          end else if (dc_rd_data_valid) begin
            remain_d = remain_q - 8'd1;
            state_d  = (remain_q == 8'd1) ? S_IDLE : S_RD_DATA;
          end else begin
            state_d = S_RD_DATA;
          end
        end
      end
      S_RD_DATA: begin
        if (dc_rd_data_valid) begin
          remain_d = remain_q - 8'd1;
          if (remain_q <= 8'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A flushed read still runs to completion, but silently.
    if (flush && rd_busy) rd_squash_d = 1'b1;
    if (state_d == S_IDLE) rd_squash_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      be_q        <= '0;
      burst_q     <= '0;
      remain_q    <= '0;
      rd_squash_q <= 1'b0;
      wr_squash_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      be_q        <= be_d;
      burst_q     <= burst_d;
      remain_q    <= remain_d;
      rd_squash_q <= rd_squash_d;
      wr_squash_q <= wr_squash_d;
    end
  end

  assign dc_wr_req         = (state_q == S_WR);
  assign dc_rd_req         = (state_q == S_RD_REQ);
  assign dc_wr_addr        = addr_q;
  assign dc_rd_addr        = addr_q;
  assign dc_wr_data        = data_q;
  assign dc_wr_be          = be_q;
  assign dc_wr_burstcnt    = 8'd1;
  assign dc_rd_burstcnt    = burst_q;
  assign cpu_rd_ack        = dc_rd_ack && (state_q == S_RD_REQ) && !rd_squash_q;
  assign cpu_rd_data_valid = dc_rd_data_valid && rd_busy && !rd_squash_q;
  assign cpu_rd_data       = dc_rd_data;
  assign wr_pending        = count_q;
  assign idle              = (state_q == S_IDLE) && (count_q == 6'd0);

endmodule

// File: tb/tb_ddram_port_sched.sv
// Directed bench for ddram_port_sched: a cycle table for write/read-bypass
// traffic, then hand-written fill, hazard, hi-water, flush and reset sequences.
module tb_ddram_port_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic [28:0] cpu_wr_addr;
  logic [63:0] cpu_wr_data;
  logic [7:0]  cpu_wr_be;
  logic        cpu_wr_req;
  logic        cpu_wr_ready;
  logic [28:0] cpu_rd_addr;
  logic [7:0]  cpu_rd_burstcnt;
  logic        cpu_rd_req;
  logic        cpu_rd_ack;
  logic [63:0] cpu_rd_data;
  logic        cpu_rd_data_valid;
  logic [28:0] dc_rd_addr;
  logic [7:0]  dc_rd_burstcnt;
  logic        dc_rd_req;
  logic        dc_rd_ack;
  logic [63:0] dc_rd_data;
  logic        dc_rd_data_valid;
  logic [28:0] dc_wr_addr;
  logic [63:0] dc_wr_data;
  logic [7:0]  dc_wr_be;
  logic [7:0]  dc_wr_burstcnt;
  logic        dc_wr_req;
  logic        dc_wr_ack;
  logic        dc_wr_busy;
  logic [5:0]  wr_pending;
  logic        idle;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ddram_port_sched #(.DEPTH(8), .WR_HIWAT(6)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data), .cpu_wr_be(cpu_wr_be),
    .cpu_wr_req(cpu_wr_req), .cpu_wr_ready(cpu_wr_ready),
    .cpu_rd_addr(cpu_rd_addr), .cpu_rd_burstcnt(cpu_rd_burstcnt), .cpu_rd_req(cpu_rd_req),
    .cpu_rd_ack(cpu_rd_ack), .cpu_rd_data(cpu_rd_data), .cpu_rd_data_valid(cpu_rd_data_valid),
    .dc_rd_addr(dc_rd_addr), .dc_rd_burstcnt(dc_rd_burstcnt), .dc_rd_req(dc_rd_req),
    .dc_rd_ack(dc_rd_ack), .dc_rd_data(dc_rd_data), .dc_rd_data_valid(dc_rd_data_valid),
    .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data), .dc_wr_be(dc_wr_be),
    .dc_wr_burstcnt(dc_wr_burstcnt), .dc_wr_req(dc_wr_req),
    .dc_wr_ack(dc_wr_ack), .dc_wr_busy(dc_wr_busy),
    .wr_pending(wr_pending), .idle(idle)
  );

  typedef struct {
    logic        wr_req;
    logic [28:0] wr_addr;
    logic        rd_req;
    logic [28:0] rd_addr;
    logic [7:0]  rd_bc;
    logic [2:0]  dn;      // {dc_rd_ack, dc_rd_data_valid, dc_wr_ack}
    logic [5:0]  ef;      // {dc_wr_req, dc_rd_req, cpu_rd_ack, cpu_rd_data_valid, cpu_wr_ready, idle}
    logic [5:0]  e_pend;
    logic [28:0] e_addr;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wreq(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (dc_wr_req !== 1'b1 && n < 16) begin
      cyc();
      @(negedge clk);
      n++;
    end
    check(nm, dc_wr_req, 1'b1);
  endtask

  task automatic push(input logic [28:0] a, input logic [63:0] d);
    cpu_wr_req  = 1'b1;
    cpu_wr_addr = a;
    cpu_wr_data = d;
    cyc();
    cpu_wr_req  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; flush = 1'b0;
    cpu_wr_addr = '0; cpu_wr_data = '0; cpu_wr_be = 8'hFF; cpu_wr_req = 1'b0;
    cpu_rd_addr = '0; cpu_rd_burstcnt = '0; cpu_rd_req = 1'b0;
    dc_rd_ack = 1'b0; dc_rd_data = '0; dc_rd_data_valid = 1'b0;
    dc_wr_ack = 1'b0; dc_wr_busy = 1'b0;

    // Single write, then read bypassing two queued writes (ack coincident with first word).
    vecs[0]  = '{1'b0, 29'h0,   1'b0, 29'h0,   8'd0, 3'b000, 6'b000011, 6'd0, 29'h0};
    vecs[1]  = '{1'b1, 29'h100, 1'b0, 29'h0,   8'd0, 3'b000, 6'b000011, 6'd0, 29'h0};
    vecs[2]  = '{1'b0, 29'h0,   1'b0, 29'h0,   8'd0, 3'b000, 6'b000010, 6'd1, 29'h0};
    vecs[3]  = '{1'b0, 29'h0,   1'b0, 29'h0,   8'd0, 3'b001, 6'b100010, 6'd1, 29'h100};
    vecs[4]  = '{1'b0, 29'h0,   1'b0, 29'h0,   8'd0, 3'b000, 6'b000011, 6'd0, 29'h100};
    vecs[5]  = '{1'b1, 29'h200, 1'b0, 29'h0,   8'd0, 3'b000, 6'b000011, 6'd0, 29'h100};
    vecs[6]  = '{1'b1, 29'h201, 1'b1, 29'h300, 8'd4, 3'b000, 6'b000010, 6'd1, 29'h100};
    vecs[7]  = '{1'b0, 29'h0,   1'b1, 29'h300, 8'd4, 3'b110, 6'b011110, 6'd2, 29'h300};
    vecs[8]  = '{1'b0, 29'h0,   1'b0, 29'h0,   8'd0, 3'b010, 6'b000110, 6'd2, 29'h300};
    vecs[9]  = '{1'b0, 29'h0,   1'b0, 29'h0,   8'd0, 3'b000, 6'b000010, 6'd2, 29'h300};
    vecs[10] = '{1'b0, 29'h0,   1'b0, 29'h0,   8'd0, 3'b010, 6'b000110, 6'd2, 29'h300};
    vecs[11] = '{1'b0, 29'h0,   1'b0, 29'h0,   8'd0, 3'b010, 6'b000110, 6'd2, 29'h300};
    vecs[12] = '{1'b0, 29'h0,   1'b0, 29'h0,   8'd0, 3'b000, 6'b000010, 6'd2, 29'h300};
    vecs[13] = '{1'b0, 29'h0,   1'b0, 29'h0,   8'd0, 3'b001, 6'b100010, 6'd2, 29'h200};
    vecs[14] = '{1'b0, 29'h0,   1'b0, 29'h0,   8'd0, 3'b000, 6'b000010, 6'd1, 29'h200};
    vecs[15] = '{1'b0, 29'h0,   1'b0, 29'h0,   8'd0, 3'b000, 6'b100010, 6'd1, 29'h201};
    vecs[16] = '{1'b0, 29'h0,   1'b0, 29'h0,   8'd0, 3'b001, 6'b100010, 6'd1, 29'h201};
    vecs[17] = '{1'b0, 29'h0,   1'b0, 29'h0,   8'd0, 3'b000, 6'b000011, 6'd0, 29'h201};

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst dc_wr_req", dc_wr_req, 1'b0);
    check("rst dc_rd_req", dc_rd_req, 1'b0);
    check("rst cpu_rd_ack", cpu_rd_ack, 1'b0);
    check("rst cpu_rd_data_valid", cpu_rd_data_valid, 1'b0);
    check("rst cpu_wr_ready", cpu_wr_ready, 1'b1);
    check("rst wr_pending", wr_pending, 6'd0);
    check("rst idle", idle, 1'b1);
    reset_n = 1'b1;
    cyc();

    for (int i = 0; i < NV; i++) begin
      cpu_wr_req       = vecs[i].wr_req;
      cpu_wr_addr      = vecs[i].wr_addr;
      cpu_wr_data      = 64'hA5A5;
      cpu_rd_req       = vecs[i].rd_req;
      cpu_rd_addr      = vecs[i].rd_addr;
      cpu_rd_burstcnt  = vecs[i].rd_bc;
      dc_rd_ack        = vecs[i].dn[2];
      dc_rd_data_valid = vecs[i].dn[1];
      dc_wr_ack        = vecs[i].dn[0];
      dc_rd_data       = 64'hD0D0_0000_0000_0000 + 64'(i);
      @(negedge clk);
      check($sformatf("vec%0d dc_wr_req", i), dc_wr_req, vecs[i].ef[5]);
      check($sformatf("vec%0d dc_rd_req", i), dc_rd_req, vecs[i].ef[4]);
      check($sformatf("vec%0d cpu_rd_ack", i), cpu_rd_ack, vecs[i].ef[3]);
      check($sformatf("vec%0d cpu_rd_data_valid", i), cpu_rd_data_valid, vecs[i].ef[2]);
      check($sformatf("vec%0d cpu_wr_ready", i), cpu_wr_ready, vecs[i].ef[1]);
      check($sformatf("vec%0d idle", i), idle, vecs[i].ef[0]);
      check($sformatf("vec%0d wr_pending", i), wr_pending, vecs[i].e_pend);
      check($sformatf("vec%0d dc_addr", i), dc_wr_addr, vecs[i].e_addr);
      if (vecs[i].ef[5]) begin
        check($sformatf("vec%0d dc_wr_data", i), dc_wr_data, 64'hA5A5);
        check($sformatf("vec%0d dc_wr_be", i), dc_wr_be, 8'hFF);
      end
      if (vecs[i].ef[2])
        check($sformatf("vec%0d cpu_rd_data", i), cpu_rd_data, 64'hD0D0_0000_0000_0000 + 64'(i));
      cyc();
    end
    cpu_wr_req = 1'b0; cpu_rd_req = 1'b0;
    dc_rd_ack = 1'b0; dc_rd_data_valid = 1'b0; dc_wr_ack = 1'b0;

    // Fill to DEPTH, ninth push held off, drain in FIFO order.
    for (int i = 0; i < 8; i++) begin
      cpu_wr_req  = 1'b1;
      cpu_wr_addr = 29'h400 + 29'(i);
      cpu_wr_data = 64'h1000 + 64'(i);
      @(negedge clk);
      check($sformatf("fill ready %0d", i), cpu_wr_ready, 1'b1);
      cyc();
    end
    cpu_wr_addr = 29'h4FF;
    @(negedge clk);
    check("fill full ready", cpu_wr_ready, 1'b0);
    check("fill full pending", wr_pending, 6'd8);
    cyc();
    cpu_wr_req = 1'b0;
    @(negedge clk);
    check("fill ninth dropped", wr_pending, 6'd8);
    cyc();
    for (int i = 0; i < 8; i++) begin
      wait_wreq($sformatf("drain req %0d", i));
      check($sformatf("drain addr %0d", i), dc_wr_addr, 29'h400 + 29'(i));
      check($sformatf("drain data %0d", i), dc_wr_data, 64'h1000 + 64'(i));
      check($sformatf("drain burstcnt %0d", i), dc_wr_burstcnt, 8'd1);
      dc_wr_ack = 1'b1;
      cyc();
      dc_wr_ack = 1'b0;
    end
    @(negedge clk);
    check("drain pending", wr_pending, 6'd0);
    check("drain idle", idle, 1'b1);
    check("drain no wr_req", dc_wr_req, 1'b0);
    cyc();

    // Hazard: queued write inside the read window drains first.
    push(29'h1FFFFFFF, 64'hBEEF);
    cpu_rd_req = 1'b1; cpu_rd_addr = 29'h1FFFFFFE; cpu_rd_burstcnt = 8'd4;
    @(negedge clk);
    check("haz idle rd_req", dc_rd_req, 1'b0);
    cyc();
    @(negedge clk);
    check("haz write first", dc_wr_req, 1'b1);
    check("haz read held", dc_rd_req, 1'b0);
    check("haz wr addr", dc_wr_addr, 29'h1FFFFFFF);
    dc_wr_ack = 1'b1;
    cyc();
    dc_wr_ack = 1'b0;
    @(negedge clk);
    check("haz gap rd_req", dc_rd_req, 1'b0);
    check("haz pending", wr_pending, 6'd0);
    cyc();
    @(negedge clk);
    check("haz read issued", dc_rd_req, 1'b1);
    check("haz rd addr", dc_rd_addr, 29'h1FFFFFFE);
    check("haz rd burstcnt", dc_rd_burstcnt, 8'd4);
    dc_rd_ack = 1'b1;
    #1;
    check("haz cpu_rd_ack", cpu_rd_ack, 1'b1);
    cyc();
    dc_rd_ack = 1'b0; cpu_rd_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dc_rd_data_valid = 1'b1;
      dc_rd_data = 64'hCAFE_0000 + 64'(k);
      @(negedge clk);
      check($sformatf("haz word %0d valid", k), cpu_rd_data_valid, 1'b1);
      check($sformatf("haz word %0d data", k), cpu_rd_data, 64'hCAFE_0000 + 64'(k));
      cyc();
    end
    dc_rd_data_valid = 1'b0;
    @(negedge clk);
    check("haz done idle", idle, 1'b1);
    cyc();

    // No hazard across the wrap: write at 0x1FFFFFFF, read 0x0 burst 1.
    push(29'h1FFFFFFF, 64'h77);
    cpu_rd_req = 1'b1; cpu_rd_addr = 29'h0; cpu_rd_burstcnt = 8'd1;
    cyc();
    @(negedge clk);
    check("nohaz read first", dc_rd_req, 1'b1);
    check("nohaz wr held", dc_wr_req, 1'b0);
    check("nohaz rd addr", dc_rd_addr, 29'h0);
    check("nohaz pending", wr_pending, 6'd1);
    dc_rd_ack = 1'b1; dc_rd_data_valid = 1'b1; dc_rd_data = 64'h1234;
    #1;
    check("nohaz cpu_rd_ack", cpu_rd_ack, 1'b1);
    check("nohaz cpu_rd_valid", cpu_rd_data_valid, 1'b1);
    cyc();
    dc_rd_ack = 1'b0; dc_rd_data_valid = 1'b0; cpu_rd_req = 1'b0;
    @(negedge clk);
    check("nohaz gap rd_req", dc_rd_req, 1'b0);
    check("nohaz gap wr_req", dc_wr_req, 1'b0);
    cyc();
    @(negedge clk);
    check("nohaz then write", dc_wr_req, 1'b1);
    check("nohaz wr addr", dc_wr_addr, 29'h1FFFFFFF);
    dc_wr_ack = 1'b1;
    cyc();
    dc_wr_ack = 1'b0;
    @(negedge clk);
    check("nohaz pending 0", wr_pending, 6'd0);
    cyc();

    // Hi-water: writes beat a held read until occupancy drops below 6.
    for (int i = 0; i < 7; i++) push(29'h500 + 29'(i), 64'h5000 + 64'(i));
    cpu_rd_req = 1'b1; cpu_rd_addr = 29'h800; cpu_rd_burstcnt = 8'd1;
    @(negedge clk);
    check("hiw first wr", dc_wr_req, 1'b1);
    check("hiw first addr", dc_wr_addr, 29'h500);
    check("hiw pending 7", wr_pending, 6'd7);
    dc_wr_ack = 1'b1;
    cyc();
    dc_wr_ack = 1'b0;
    @(negedge clk);
    check("hiw pending 6", wr_pending, 6'd6);
    cyc();
    @(negedge clk);
    check("hiw wr beats rd", dc_wr_req, 1'b1);
    check("hiw rd held", dc_rd_req, 1'b0);
    check("hiw second addr", dc_wr_addr, 29'h501);
    dc_wr_ack = 1'b1;
    cyc();
    dc_wr_ack = 1'b0;
    @(negedge clk);
    check("hiw pending 5", wr_pending, 6'd5);
    cyc();
    @(negedge clk);
    check("hiw read at 5", dc_rd_req, 1'b1);
    check("hiw wr held at 5", dc_wr_req, 1'b0);
    check("hiw rd addr", dc_rd_addr, 29'h800);
    dc_rd_ack = 1'b1; dc_rd_data_valid = 1'b1;
    cyc();
    dc_rd_ack = 1'b0; dc_rd_data_valid = 1'b0; cpu_rd_req = 1'b0;
    for (int i = 2; i < 7; i++) begin
      wait_wreq($sformatf("hiw drain req %0d", i));
      check($sformatf("hiw drain addr %0d", i), dc_wr_addr, 29'h500 + 29'(i));
      dc_wr_ack = 1'b1;
      cyc();
      dc_wr_ack = 1'b0;
    end
    @(negedge clk);
    check("hiw empty", wr_pending, 6'd0);
    cyc();

    // Flush mid-read: 3 of 8 words in, 4 queued writes plus a coincident push.
    cpu_rd_req = 1'b1; cpu_rd_addr = 29'h900; cpu_rd_burstcnt = 8'd8;
    cyc();
    @(negedge clk);
    check("fl rd_req", dc_rd_req, 1'b1);
    dc_rd_ack = 1'b1;
    #1;
    check("fl cpu_rd_ack", cpu_rd_ack, 1'b1);
    cyc();
    dc_rd_ack = 1'b0; cpu_rd_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cpu_wr_req = 1'b1; cpu_wr_addr = 29'hA00 + 29'(k); cpu_wr_data = 64'(k);
      dc_rd_data_valid = (k < 3);
      @(negedge clk);
      check($sformatf("fl pre word %0d", k), cpu_rd_data_valid, (k < 3));
      cyc();
    end
    cpu_wr_addr = 29'hA04; dc_rd_data_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("fl ready low", cpu_wr_ready, 1'b0);
    check("fl pending 4", wr_pending, 6'd4);
    cyc();
    flush = 1'b0; cpu_wr_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      dc_rd_data_valid = 1'b1;
      @(negedge clk);
      check($sformatf("fl squashed word %0d", k), cpu_rd_data_valid, 1'b0);
      check($sformatf("fl pending 0 %0d", k), wr_pending, 6'd0);
      cyc();
    end
    dc_rd_data_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("fl no wr_req %0d", k), dc_wr_req, 1'b0);
      check($sformatf("fl no rd_req %0d", k), dc_rd_req, 1'b0);
      check($sformatf("fl idle %0d", k), idle, 1'b1);
      cyc();
    end

    // Reset mid-transaction aborts immediately.
    push(29'hC00, 64'h99);
    wait_wreq("mrst wr_req");
    reset_n = 1'b0;
    #1;
    check("mrst dc_wr_req", dc_wr_req, 1'b0);
    check("mrst pending", wr_pending, 6'd0);
    check("mrst idle", idle, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
    @(negedge clk);
    check("mrst stays idle", dc_wr_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
